drive_ctrl: RTL

- Bridge-drive sequencer directly downstream of the interrupter generator: consumes its `out` pulse as `int_in` and converts each interrupter window into a feedback-locked burst of complementary H-bridge gate signals.
- Behaviour per burst: hard start, dead-time-protected commutation on each current-feedback edge, soft stop at a current zero crossing, over-current cutoff.
- Sits between the interrupter generator and the gate-driver pins.

---
 rtl/drive_pkg.sv | 17 +
 rtl/drive_ctrl_sync2.sv | 31 +++
 rtl/drive_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/drive_pkg.sv
// Shared types and default constants for the bridge-drive sequencer.
package drive_pkg;

    localparam int unsigned CLK_MHZ_DEF    = 100;
    localparam int unsigned DT_MAX_DEF     = 63;
    localparam int unsigned START_CYC_DEF  = 200;
    localparam int unsigned FB_TIMEOUT_DEF = 1000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

endpackage

// File: rtl/drive_ctrl_sync2.sv
// Two-flop synchronizer with synchronous active-high reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/drive_ctrl.sv
// Feedback-locked H-bridge burst sequencer with dead time and over-current cutoff.
// OCD_LATCH_EN: when defined, FAULT is left only through rst.
module drive_ctrl
    import drive_pkg::*;
#(
    parameter int unsigned DT_MAX     = DT_MAX_DEF,
    parameter int unsigned START_CYC  = START_CYC_DEF,
    parameter int unsigned FB_TIMEOUT = FB_TIMEOUT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        int_in,
    input  logic                        fb_in,
    input  logic                        ocd_in,
    input  logic [$clog2(DT_MAX+1)-1:0] dt_par,
    output logic                        gate_a,
    output logic                        gate_b,
    output logic                        active,
    output logic                        fault
);

    localparam int unsigned DT_W    = $clog2(DT_MAX + 1);
    localparam int unsigned START_W = $clog2(START_CYC) + 1;
    localparam int unsigned TO_W    = $clog2(FB_TIMEOUT) + 1;

    logic fb_s;
    logic ocd_s;
    logic fb_edge;
    logic int_rise;

    state_e             state_q,     state_d;
    logic               fb_d_q,      fb_d_d;
    logic               int_prev_q,  int_prev_d;
    logic               gate_a_q,    gate_a_d;
    logic               gate_b_q,    gate_b_d;
    logic               active_q,    active_d;
    logic               fault_q,     fault_d;
    logic               dt_busy_q,   dt_busy_d;
    logic               dt_tgt_q,    dt_tgt_d;
    logic [DT_W-1:0]    dt_cnt_q,    dt_cnt_d;
    logic [START_W-1:0] start_cnt_q, start_cnt_d;
    logic [TO_W-1:0]    to_cnt_q,    to_cnt_d;

    logic commutate;
    logic dt_step;
    logic fb_timeout;
    logic start_expired;

    sync2 u_sync_fb (
        .clk (clk),
        .rst (rst),
        .d   (fb_in),
        .q   (fb_s)
    );

    sync2 u_sync_ocd (
        .clk (clk),
        .rst (rst),
        .d   (ocd_in),
        .q   (ocd_s)
    );

    assign fb_edge       = fb_s ^ fb_d_q;
    assign int_rise      = int_in & ~int_prev_q;
    assign fb_timeout    = (to_cnt_q == TO_W'(FB_TIMEOUT - 1));
    assign start_expired = (start_cnt_q == START_W'(START_CYC - 1));

    // Next-state, counters and gate drive
    always_comb begin
        state_d     = state_q;
        fb_d_d      = fb_s;
        int_prev_d  = int_in;
        gate_a_d    = gate_a_q;
        gate_b_d    = gate_b_q;
        dt_busy_d   = dt_busy_q;
        dt_tgt_d    = dt_tgt_q;
        dt_cnt_d    = dt_cnt_q;
        start_cnt_d = start_cnt_q;
        to_cnt_d    = to_cnt_q;
        commutate   = 1'b0;
        dt_step     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (int_rise) begin
                    state_d     = ST_START;
                    gate_a_d    = 1'b1;
                    gate_b_d    = 1'b0;
                    start_cnt_d = '0;
                end
            end
            ST_START: begin
                if (ocd_s) begin
                    state_d = ST_FAULT;
                end else if (!int_in) begin
                    state_d = ST_IDLE;
                end else if (fb_edge) begin
                    state_d   = ST_RUN;
                    commutate = 1'b1;
                    to_cnt_d  = '0;
                end else if (start_expired) begin
                    state_d = ST_IDLE;
                end else if (start_cnt_q != '1) begin
                    start_cnt_d = start_cnt_q + START_W'(1);
                end
            end
            ST_RUN: begin
                if (ocd_s) begin
                    state_d = ST_FAULT;
                end else begin
                    dt_step = 1'b1;
                    if (fb_edge) begin
                        commutate = 1'b1;
                        to_cnt_d  = '0;
                    end else if (fb_timeout) begin
                        state_d = ST_IDLE;
                    end else if (to_cnt_q != '1) begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                    // Window closed: hold the present gate and wait for a zero crossing
                    if (!int_in && (fb_edge || !fb_timeout)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (ocd_s) begin
                    state_d = ST_FAULT;
                end else if (fb_edge || fb_timeout) begin
                    state_d = ST_IDLE;
                end else begin
                    dt_step = 1'b1;
                    if (to_cnt_q != '1) begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
            ST_FAULT: begin
`ifdef OCD_LATCH_EN
                state_d = ST_FAULT;
`else
                if (!int_in && !ocd_s) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pending dead time elapses into the target gate
        if (dt_step && dt_busy_q) begin
            if (dt_cnt_q <= DT_W'(1)) begin
                dt_busy_d = 1'b0;
                gate_a_d  = dt_tgt_q;
                gate_b_d  = ~dt_tgt_q;
            end else begin
                dt_cnt_d = dt_cnt_q - DT_W'(1);
            end
        end

        // A fresh feedback edge restarts the dead time toward the new polarity
        if (commutate) begin
            if (dt_par == '0) begin
                dt_busy_d = 1'b0;
                gate_a_d  = fb_s;
                gate_b_d  = ~fb_s;
            end else begin
                dt_busy_d = 1'b1;
                dt_cnt_d  = dt_par;
                dt_tgt_d  = fb_s;
                gate_a_d  = 1'b0;
                gate_b_d  = 1'b0;
            end
        end

        if (state_d == ST_IDLE || state_d == ST_FAULT) begin
            gate_a_d  = 1'b0;
            gate_b_d  = 1'b0;
            dt_busy_d = 1'b0;
        end

        active_d = (state_d == ST_START) || (state_d == ST_RUN) || (state_d == ST_STOP);
        fault_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fb_d_q      <= 1'b0;
            int_prev_q  <= 1'b0;
            gate_a_q    <= 1'b0;
            gate_b_q    <= 1'b0;
            active_q    <= 1'b0;
            fault_q     <= 1'b0;
            dt_busy_q   <= 1'b0;
            dt_tgt_q    <= 1'b0;
            dt_cnt_q    <= '0;
            start_cnt_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            fb_d_q      <= fb_d_d;
            int_prev_q  <= int_prev_d;
            gate_a_q    <= gate_a_d;
            gate_b_q    <= gate_b_d;
            active_q    <= active_d;
            fault_q     <= fault_d;
            dt_busy_q   <= dt_busy_d;
            dt_tgt_q    <= dt_tgt_d;
            dt_cnt_q    <= dt_cnt_d;
            start_cnt_q <= start_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign gate_a = gate_a_q;
    assign gate_b = gate_b_q;
    assign active = active_q;
    assign fault  = fault_q;

endmodule
